// File: rtl/shift_sequencer.sv
// Multi-cycle controller around the shared single-step ALU: iterates shift/rotate ops
// one bit per clock, tracking CF between steps; single-pass ops take one ALU step.
module shift_sequencer (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [15:0] op1,
   input  logic [15:0] op2,
   input  logic        bit16,
   input  logic [11:0] flags_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic [11:0] flags_out,
   output logic [3:0]  alu_sel,
   output logic [15:0] alu_op1,
   output logic [15:0] alu_op2,
   output logic        alu_bit16,
   output logic [11:0] alu_flags,
   input  logic [15:0] alu_result,
   input  logic [11:0] alu_flags_res
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_nxt;
   logic [3:0]  op_q;
   logic [15:0] op2_q;
   logic        bit16_q;
   logic [15:0] acc;
   logic [11:0] flg;
   logic [4:0]  cnt;
   logic        skip;

   logic [4:0]  n_start;
   logic        last;
   logic [15:0] acc_step;
   logic [11:0] flg_step;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      n_start  = op[3] ? op2[4:0] : 5'd1;
      last     = (cnt == 5'd1);
      acc_step = bit16_q ? alu_result : {8'h00, alu_result[7:0]};
      flg_step = flg;
      if (!op_q[3])
         flg_step = alu_flags_res;
      else if (!op_q[0])
         flg_step[0] = bit16_q ? acc[15] : acc[7];
      else
         flg_step[0] = acc[0];
      // A zero shift count still spends one RUN cycle, but leaves value and flags alone.
      if (skip) begin
         acc_step = acc;
         flg_step = flg;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_q      <= '0;
         op2_q     <= '0;
         bit16_q   <= 1'b0;
         acc       <= '0;
         flg       <= '0;
         cnt       <= '0;
         skip      <= 1'b0;
         result    <= '0;
         flags_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q    <= op;
                  op2_q   <= op2;
                  bit16_q <= bit16;
                  acc     <= bit16 ? op1 : {8'h00, op1[7:0]};
                  flg     <= flags_in;
                  cnt     <= (n_start == 5'd0) ? 5'd1 : n_start;
                  skip    <= (n_start == 5'd0);
               end
            end
            RUN: begin
               acc <= acc_step;
               flg <= flg_step;
               cnt <= cnt - 5'd1;
               if (last) begin
                  result    <= acc_step;
                  flags_out <= flg_step;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign alu_sel   = op_q;
   assign alu_op1   = acc;
   assign alu_op2   = op2_q;
   assign alu_bit16 = bit16_q;
   assign alu_flags = flg;

endmodule
